// File: rtl/uart_hex_receiver.sv
// 8N1 UART receiver that keeps ASCII hex digits and shifts them into a 16-bit display value.
// Optional build macro UART_HEX_CLEAR_EN: an accepted CR or ESC byte clears data.
module uart_hex_receiver #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] data,
  output logic        digit_stb,
  output logic        frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic          rx_meta;
  logic          rx_sync;
  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          byte_done;
  logic          byte_ok;
  logic          is_hex;
  logic [3:0]    nibble;

  // Two-flop synchronizer; resets to the idle line level so reset itself is not a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      byte_done <= 1'b0;
      byte_ok   <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (!rx_sync) state <= START;
        end
        START: begin
          if (timer == HALF_LAST) begin
            timer   <= '0;
            bit_idx <= 3'd0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            shift <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid stop bit leaves half a bit to spot a back-to-back start edge.
          if (timer == BIT_LAST) begin
            timer     <= '0;
            byte_done <= 1'b1;
            byte_ok   <= rx_sync;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (shift >= 8'h30 && shift <= 8'h39) begin
      is_hex = 1'b1;
      nibble = shift[3:0];
    end else if ((shift >= 8'h41 && shift <= 8'h46) || (shift >= 8'h61 && shift <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = shift[3:0] + 4'd9;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= 16'h0000;
      digit_stb <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      digit_stb <= 1'b0;
      frame_err <= 1'b0;
      if (byte_done) begin
        if (!byte_ok) begin
          frame_err <= 1'b1;
        end else if (is_hex) begin
          data      <= {data[11:0], nibble};
          digit_stb <= 1'b1;
        end
`ifdef UART_HEX_CLEAR_EN
        else if (shift == 8'h0D || shift == 8'h1B) begin
          data <= 16'h0000;
        end
`else
        else begin
          data <= data;
        end
`endif
      end
    end
  end

endmodule
